// File: rtl/branch_hazard_pkg.sv
// Shared constants for the ID-stage branch hazard controller.
package branch_hazard_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned STALL_W    = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [STALL_W-1:0] STALL_NONE     = 2'd0;
  localparam logic [STALL_W-1:0] STALL_LOAD_EX  = 2'd2;
  localparam logic [STALL_W-1:0] STALL_ALU_EX   = 2'd1;
  localparam logic [STALL_W-1:0] STALL_LOAD_MEM = 2'd1;

endpackage

// File: rtl/branch_dep_detect.sv
// Per-source dependency check: required stall cycles and EX/MEM forward select.
module branch_dep_detect
  import branch_hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0]  src,
  input  logic               idex_regwrite,
  input  logic               idex_memread,
  input  logic [REG_AW-1:0]  idex_rd,
  input  logic               exmem_regwrite,
  input  logic               exmem_memread,
  input  logic [REG_AW-1:0]  exmem_rd,
  output logic [STALL_W-1:0] n_stall,
  output logic               fwd
);

  logic idex_hit;
  logic exmem_hit;

  // $0 is hardwired, so it never creates a dependency
  assign idex_hit  = (src != '0) && idex_regwrite  && (idex_rd  == src);
  assign exmem_hit = (src != '0) && exmem_regwrite && (exmem_rd == src);

  always_comb begin
    n_stall = STALL_NONE;
    fwd     = 1'b0;
    if (idex_hit) begin
      n_stall = idex_memread ? STALL_LOAD_EX : STALL_ALU_EX;
    end else if (exmem_hit) begin
      if (exmem_memread) begin
        n_stall = STALL_LOAD_MEM;
      end else begin
        fwd = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch hazard controller: stalls or forwards for the ID-stage comparator.
// Optional stall statistics counter enabled by BRANCH_STALL_STATS_EN.
module branch_hazard_ctrl
  import branch_hazard_pkg::*;
#(
  parameter int unsigned REG_AW    = REG_AW_DEF,
  parameter int unsigned MAX_STALL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IDBranch,
  input  logic              IDBranchTaken,
  input  logic [REG_AW-1:0] IDRs,
  input  logic [REG_AW-1:0] IDRt,
  input  logic              IDEXRegWrite,
  input  logic              IDEXMemRead,
  input  logic [REG_AW-1:0] IDEXRd,
  input  logic              EXMEMRegWrite,
  input  logic              EXMEMMemRead,
  input  logic [REG_AW-1:0] EXMEMRd,
  output logic              Stall,
  output logic              FwA,
  output logic              FwB,
  output logic              IFFlush
`ifdef BRANCH_STALL_STATS_EN
  ,
  output logic [15:0]       StallCount
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] n_rs, n_rt, n_max;
  logic               fwd_rs, fwd_rt;
  logic               stall_c, fwa_c, fwb_c;

  branch_dep_detect #(.REG_AW(REG_AW)) u_dep_rs (
    .src(IDRs), .idex_regwrite(IDEXRegWrite), .idex_memread(IDEXMemRead),
    .idex_rd(IDEXRd), .exmem_regwrite(EXMEMRegWrite),
    .exmem_memread(EXMEMMemRead), .exmem_rd(EXMEMRd),
    .n_stall(n_rs), .fwd(fwd_rs)
  );

  branch_dep_detect #(.REG_AW(REG_AW)) u_dep_rt (
    .src(IDRt), .idex_regwrite(IDEXRegWrite), .idex_memread(IDEXMemRead),
    .idex_rd(IDEXRd), .exmem_regwrite(EXMEMRegWrite),
    .exmem_memread(EXMEMMemRead), .exmem_rd(EXMEMRd),
    .n_stall(n_rt), .fwd(fwd_rt)
  );

  assign n_max = (n_rs > n_rt) ? n_rs : n_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and raw outputs; WAIT ignores dependencies until the count expires
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    fwa_c   = 1'b0;
    fwb_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (IDBranch) begin
          if (n_max != STALL_NONE) begin
            stall_c = 1'b1;
            cnt_d   = CNT_W'(n_max - STALL_W'(1));
            state_d = (n_max > STALL_W'(1)) ? ST_WAIT : ST_IDLE;
          end else begin
            fwa_c = fwd_rs;
            fwb_c = fwd_rt;
          end
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are combinational, so they are masked while reset is held
  assign Stall   = rst_n & stall_c;
  assign FwA     = rst_n & fwa_c;
  assign FwB     = rst_n & fwb_c;
  assign IFFlush = rst_n & IDBranch & IDBranchTaken & ~stall_c;

`ifdef BRANCH_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule
